// File: rtl/ysyx_22050039_mem_stage_pkg.sv
// Shared constants for the ysyx_22050039 load/store unit: access sizes,
// FSM encoding and the byte-enable width of the data-memory port.
package ysyx_22050039_mem_stage_pkg;

  localparam int MEM_MASK_W = 8;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  localparam int F3_UNS_BIT   = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  function automatic logic [MEM_MASK_W-1:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    size_mask = 8'h01;
      SZ_H:    size_mask = 8'h03;
      SZ_W:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22050039_mem_stage_lsu_align.sv
// Combinational lane logic: legality/alignment check, store byte-lane shift
// and load extract with sign/zero extension.
module ysyx_22050039_lsu_align
  import ysyx_22050039_mem_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic                  store_i,
  input  logic [2:0]            funct3_i,
  input  logic [2:0]            off_i,
  input  logic [XLEN-1:0]       wdata_i,
  input  logic [XLEN-1:0]       rdata_i,
  output logic                  err_o,
  output logic [MEM_MASK_W-1:0] wmask_o,
  output logic [XLEN-1:0]       wdata_o,
  output logic [XLEN-1:0]       rdata_o
);

  logic [1:0]      sz;
  logic            uns, illegal, misalign, ext;
  logic [5:0]      sh;
  logic [XLEN-1:0] lane;

  assign sz  = funct3_i[1:0];
  assign uns = funct3_i[F3_UNS_BIT];
  assign sh  = {off_i, 3'b000};

  // 111 is never a load/store; stores have no unsigned variants.
  assign illegal = (funct3_i == 3'b111) | (store_i & funct3_i[F3_UNS_BIT]);

  always_comb begin
    case (sz)
      SZ_H:    misalign = off_i[0];
      SZ_W:    misalign = |off_i[1:0];
      SZ_D:    misalign = |off_i;
      default: misalign = 1'b0;
    endcase
  end

  assign err_o   = illegal | misalign;
  assign wmask_o = size_mask(sz) << off_i;
  assign wdata_o = wdata_i << sh;
  assign lane    = rdata_i >> sh;

  always_comb begin
    ext     = 1'b0;
    rdata_o = lane;
    case (sz)
      SZ_B: begin
        ext     = ~uns & lane[7];
        rdata_o = {{(XLEN-8){ext}}, lane[7:0]};
      end
      SZ_H: begin
        ext     = ~uns & lane[15];
        rdata_o = {{(XLEN-16){ext}}, lane[15:0]};
      end
      SZ_W: begin
        ext     = ~uns & lane[31];
        rdata_o = {{(XLEN-32){ext}}, lane[31:0]};
      end
      default: rdata_o = lane;
    endcase
  end

endmodule

// File: rtl/ysyx_22050039_mem_stage.sv
// Load/store unit: latches one EXU request, runs a valid/ready transaction
// on the data-memory port and returns one resp_valid pulse with result/error.
module ysyx_22050039_mem_stage
  import ysyx_22050039_mem_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [XLEN-1:0]       req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [XLEN-1:0]       mem_addr,
  output logic                  mem_wen,
  output logic [XLEN-1:0]       mem_wdata,
  output logic [MEM_MASK_W-1:0] mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [XLEN-1:0]       mem_rdata
);

  if (XLEN != 64) begin : g_xlen_chk
    $error("ysyx_22050039_mem_stage supports XLEN=64 only");
  end

  lsu_state_e      state_q, state_d;
  logic            store_q, err_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;

  logic                  idle, in_req, accept;
  logic                  sel_store;
  logic [2:0]            sel_funct3, sel_off;
  logic [XLEN-1:0]       sel_wdata;
  logic                  al_err;
  logic [MEM_MASK_W-1:0] al_wmask;
  logic [XLEN-1:0]       al_wdata, al_rdata;

  assign idle   = (state_q == S_IDLE);
  assign in_req = (state_q == S_REQ);
  assign accept = idle & req_valid;

  // In IDLE the align unit checks the incoming request; afterwards it works
  // from the latched copy so the memory-side fields stay stable.
  assign sel_store  = idle ? req_store     : store_q;
  assign sel_funct3 = idle ? req_funct3    : funct3_q;
  assign sel_off    = idle ? req_addr[2:0] : addr_q[2:0];
  assign sel_wdata  = idle ? req_wdata     : wdata_q;

  ysyx_22050039_lsu_align #(.XLEN(XLEN)) u_align (
    .store_i  (sel_store),
    .funct3_i (sel_funct3),
    .off_i    (sel_off),
    .wdata_i  (sel_wdata),
    .rdata_i  (mem_rdata),
    .err_o    (al_err),
    .wmask_o  (al_wmask),
    .wdata_o  (al_wdata),
    .rdata_o  (al_rdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid)      state_d = al_err ? S_DONE : S_REQ;
      S_REQ:  if (mem_req_ready)  state_d = S_WAIT;
      S_WAIT: if (mem_resp_valid) state_d = S_DONE;
      default:                    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      store_q  <= 1'b0;
      err_q    <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        store_q  <= req_store;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= al_err;
        rdata_q  <= '0;
      end else if ((state_q == S_WAIT) && mem_resp_valid && !store_q) begin
        rdata_q <= al_rdata;
      end
    end
  end

  assign req_ready     = idle;
  assign resp_valid    = (state_q == S_DONE);
  assign resp_err      = resp_valid & err_q;
  assign resp_rdata    = rdata_q;
  assign mem_req_valid = in_req;
  assign mem_addr      = in_req ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign mem_wen       = in_req & store_q;
  assign mem_wdata     = in_req ? al_wdata : '0;
  assign mem_wmask     = in_req ? al_wmask : '0;

endmodule

// File: tb/tb_ysyx_22050039_mem_stage.sv
// Randomized bench for the load/store unit against a byte-level reference model.
module tb_ysyx_22050039_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  ysyx_22050039_mem_stage #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        err;
    logic [63:0] addr, wdata, rdata;
    logic [7:0]  wmask;
  } model_t;

  // Byte-granular model: size in bytes, offset in bytes, extract/extend by hand.
  function automatic model_t ref_model(input bit st, input bit [2:0] f3,
                                       input logic [63:0] a, input logic [63:0] wd,
                                       input logic [63:0] rd);
    model_t m;
    int nb  = 1 << f3[1:0];
    int off = int'(a[2:0]);
    m.err   = (f3 == 3'b111) || (st && f3[2]) || ((off % nb) != 0);
    m.addr  = a & ~64'h7;
    m.wdata = wd << (off * 8);
    m.wmask = '0;
    m.rdata = '0;
    if (!m.err) begin
      for (int b = 0; b < nb; b++) m.wmask[off + b] = 1'b1;
      if (!st) begin
        for (int b = 0; b < nb; b++) m.rdata[b*8 +: 8] = rd[(off + b)*8 +: 8];
        if (!f3[2] && nb < 8 && m.rdata[nb*8 - 1])
          m.rdata = m.rdata | ~((64'd1 << (nb*8)) - 64'd1);
      end
    end
    return m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle expectations, written by the driver, checked on the falling edge.
  bit          chk_en = 0;
  logic        e_req_ready, e_resp_valid, e_resp_err, e_mem_req_valid, e_wen;
  logic [63:0] e_addr, e_wdata, e_rdata;
  logic [7:0]  e_wmask;
  bit          c_err, c_wen, c_addr, c_wdata, c_wmask, c_rdata;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 64'(req_ready), 64'(e_req_ready));
      chk("resp_valid", 64'(resp_valid), 64'(e_resp_valid));
      chk("mem_req_valid", 64'(mem_req_valid), 64'(e_mem_req_valid));
      if (c_err)   chk("resp_err", 64'(resp_err), 64'(e_resp_err));
      if (c_wen)   chk("mem_wen", 64'(mem_wen), 64'(e_wen));
      if (c_addr)  chk("mem_addr", mem_addr, e_addr);
      if (c_wdata) chk("mem_wdata", mem_wdata, e_wdata);
      if (c_wmask) chk("mem_wmask", 64'(mem_wmask), 64'(e_wmask));
      if (c_rdata) chk("resp_rdata", resp_rdata, e_rdata);
    end
  end

  task automatic exp_clear();
    e_req_ready = 0; e_resp_valid = 0; e_resp_err = 0; e_mem_req_valid = 0;
    e_wen = 0; e_addr = '0; e_wdata = '0; e_wmask = '0; e_rdata = '0;
    c_err = 0; c_wen = 0; c_addr = 0; c_wdata = 0; c_wmask = 0; c_rdata = 0;
  endtask

  task automatic exp_idle();
    exp_clear();
    e_req_ready = 1; c_err = 1; c_wen = 1; c_wdata = 1; c_wmask = 1;
  endtask

  task automatic exp_reset();
    exp_idle();
    c_addr = 1; c_rdata = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic garbage_req(input bit v);
    req_valid  = v;
    req_store  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = {$urandom, $urandom};
    req_wdata  = {$urandom, $urandom};
  endtask

  task automatic idle_cycles(input int n);
    garbage_req(0);
    for (int i = 0; i < n; i++) begin
      exp_idle();
      mem_resp_valid = 1'($urandom);   // stray responses in IDLE must be ignored
      mem_req_ready  = 1'($urandom);
      step();
    end
    mem_resp_valid = 0;
    mem_req_ready  = 0;
  endtask

  task automatic txn(input bit st, input bit [2:0] f3, input logic [63:0] a,
                     input logic [63:0] wd, input logic [63:0] rd,
                     input int rdy_dly, input int rsp_dly, input bit hold_next);
    model_t m = ref_model(st, f3, a, wd, rd);
    exp_idle();
    req_valid = 1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    mem_req_ready = 0; mem_resp_valid = 0;
    step();
    garbage_req(0);
    if (!m.err) begin
      for (int i = 0; i <= rdy_dly; i++) begin
        exp_clear();
        e_mem_req_valid = 1; c_wen = 1; e_wen = st; c_addr = 1; e_addr = m.addr;
        c_wdata = st; e_wdata = m.wdata; c_wmask = st; e_wmask = m.wmask;
        mem_req_ready  = (i == rdy_dly);
        mem_resp_valid = 1'($urandom);   // early response, must be ignored
        mem_rdata      = {$urandom, $urandom};
        step();
      end
      mem_req_ready = 0;
      for (int j = 0; j <= rsp_dly; j++) begin
        exp_clear();
        mem_resp_valid = (j == rsp_dly);
        mem_rdata      = (j == rsp_dly) ? rd : {$urandom, $urandom};
        mem_req_ready  = 1'($urandom);
        step();
      end
    end
    exp_clear();
    e_resp_valid = 1; c_err = 1; e_resp_err = m.err;
    c_rdata = !m.err; e_rdata = m.rdata;
    mem_resp_valid = 1'($urandom);
    mem_req_ready  = 1'($urandom);
    mem_rdata      = {$urandom, $urandom};
    garbage_req(hold_next);            // must not be accepted while in DONE
    step();
    mem_resp_valid = 0;
    mem_req_ready  = 0;
  endtask

  initial begin
    model_t m;
    rst = 0;
    req_valid = 0; req_store = 0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;

    // Literal pins of the model.
    m = ref_model(0, 3'b010, 64'h8000_0004, 64'h0, 64'h8000_0001_1234_5678);
    chk("pin_lw_rdata", m.rdata, 64'hFFFF_FFFF_8000_0001);
    chk("pin_lw_addr", m.addr, 64'h8000_0000);
    m = ref_model(0, 3'b100, 64'h8000_0007, 64'h0, 64'hAB00_0000_0000_0000);
    chk("pin_lbu_rdata", m.rdata, 64'hAB);
    m = ref_model(0, 3'b000, 64'h8000_0007, 64'h0, 64'hAB00_0000_0000_0000);
    chk("pin_lb_rdata", m.rdata, 64'hFFFF_FFFF_FFFF_FFAB);
    m = ref_model(1, 3'b001, 64'h8000_0002, 64'h0000_0000_0000_BEEF, 64'h0);
    chk("pin_sh_wmask", 64'(m.wmask), 64'h0C);
    chk("pin_sh_wdata", m.wdata, 64'h0000_0000_BEEF_0000);
    m = ref_model(1, 3'b011, 64'h8000_0004, 64'h0, 64'h0);
    chk("pin_sd_err", 64'(m.err), 64'h1);
    m = ref_model(1, 3'b100, 64'h0, 64'h0, 64'h0);
    chk("pin_store_f3_1xx_err", 64'(m.err), 64'h1);

    exp_reset();
    chk_en = 1;
    step();
    step();
    rst = 1;
    idle_cycles(2);

    // Directed cases.
    txn(0, 3'b010, 64'h8000_0004, 64'h0, 64'h8000_0001_1234_5678, 0, 0, 0);
    txn(0, 3'b100, 64'h8000_0007, 64'h0, 64'hAB00_0000_0000_0000, 0, 0, 1);
    txn(0, 3'b000, 64'h8000_0007, 64'h0, 64'hAB00_0000_0000_0000, 0, 0, 0);
    txn(1, 3'b001, 64'h8000_0002, 64'h1234_5678_9ABC_BEEF, 64'h0, 0, 0, 0);
    txn(1, 3'b011, 64'h8000_0004, 64'h1, 64'h0, 0, 0, 1);
    txn(0, 3'b111, 64'h8000_0000, 64'h0, 64'h0, 0, 0, 0);
    txn(1, 3'b011, 64'h8000_0010, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 5, 3, 1);
    txn(0, 3'b011, 64'h8000_0018, 64'h0, 64'h0123_4567_89AB_CDEF, 5, 3, 0);

    // Reset asserted while the load waits for memory.
    exp_idle();
    req_valid = 1; req_store = 0; req_funct3 = 3'b010; req_addr = 64'h100; req_wdata = '0;
    step();
    garbage_req(0);
    exp_clear();
    e_mem_req_valid = 1; c_addr = 1; e_addr = 64'h100;
    mem_req_ready = 1;
    step();
    mem_req_ready = 0;
    exp_clear();
    #1;
    rst = 0;
    exp_reset();
    step();
    step();
    rst = 1;
    exp_idle();
    mem_resp_valid = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    step();
    mem_resp_valid = 0;
    txn(0, 3'b101, 64'h202, 64'h0, 64'h0000_0000_8001_0000, 1, 1, 0);

    // Randomized traffic.
    for (int k = 0; k < 150; k++) begin
      bit          st  = 1'($urandom);
      bit [2:0]    f3  = 3'($urandom);
      logic [63:0] a   = {$urandom, $urandom};
      logic [2:0]  am;
      if (st && ($urandom % 4 != 0)) f3[2] = 1'b0;
      am = 3'((1 << f3[1:0]) - 1);
      if ($urandom % 4 != 0) a[2:0] = a[2:0] & ~am;
      txn(st, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
          int'($urandom % 4), int'($urandom % 4), 1'($urandom));
      if ($urandom % 3 == 0) idle_cycles(int'($urandom % 3) + 1);
    end
    idle_cycles(2);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
